// File: rtl/ucie_ctl_sb_pkg.sv
// Sideband message constants shared by the RX decoder and the TX code register files:
// opcode/msgcode/subcode tables, header bit positions and the decoder state encoding.
package ucie_ctl_sb_pkg;

    localparam int unsigned HDR_W        = 64;
    localparam int unsigned OPC_W        = 5;
    localparam int unsigned MSGC_W       = 8;
    localparam int unsigned SUBC_W       = 8;
    localparam int unsigned INFO_W       = 16;
    localparam int unsigned N_CODES      = 4;

    localparam int unsigned HDR_OPC_LSB  = 0;
    localparam int unsigned HDR_MSGC_LSB = 14;
    localparam int unsigned HDR_SUBC_LSB = 32;
    localparam int unsigned HDR_INFO_LSB = 40;
    localparam int unsigned HDR_DP_BIT   = 62;
    localparam int unsigned HDR_CP_BIT   = 63;

    localparam logic [OPC_W-1:0] OPC_MSG_NODATA = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_MSG_DATA   = 5'b11011;

    // Element [i] is the code reported as index i.
    localparam logic [N_CODES-1:0][MSGC_W-1:0] MSGCODE_TBL = {8'h09, 8'h04, 8'h03, 8'h01};
    localparam logic [N_CODES-1:0][SUBC_W-1:0] SUBCODE_TBL = {8'h09, 8'h02, 8'h01, 8'h00};

    typedef enum logic [1:0] {
        SB_RX_IDLE,
        SB_RX_DATA,
        SB_RX_OUT
    } sb_rx_state_e;

    function automatic logic hdr_cp_ok(input logic [HDR_W-1:0] hdr);
        return hdr[HDR_CP_BIT] == (^hdr[HDR_DP_BIT-1:0]);
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_rx_decoder_if.sv
// Sideband RX decoder bus: word input handshake, decoded message handshake and error reporting.
interface ucie_ctl_sb_rx_decoder_if #(
    parameter int unsigned ERR_CNT_WIDTH = 8
);
    logic                     i_sb_valid;
    logic [63:0]              i_sb_data;
    logic                     o_sb_ready;
    logic                     o_msg_valid;
    logic                     i_msg_ready;
    logic                     o_op_addr;
    logic [1:0]               o_msg_addr;
    logic [1:0]               o_sub_addr;
    logic [15:0]              o_info_code;
    logic [63:0]              o_data;
    logic                     o_err_opcode;
    logic                     o_err_parity;
    logic                     o_err_code;
    logic [ERR_CNT_WIDTH-1:0] o_err_cnt;

    modport master (
        output i_sb_valid, i_sb_data, i_msg_ready,
        input  o_sb_ready, o_msg_valid, o_op_addr, o_msg_addr, o_sub_addr,
               o_info_code, o_data, o_err_opcode, o_err_parity, o_err_code, o_err_cnt
    );

    modport slave (
        input  i_sb_valid, i_sb_data, i_msg_ready,
        output o_sb_ready, o_msg_valid, o_op_addr, o_msg_addr, o_sub_addr,
               o_info_code, o_data, o_err_opcode, o_err_parity, o_err_code, o_err_cnt
    );
endinterface

// File: rtl/ucie_ctl_sb_rx_code_lookup.sv
// Combinational map from raw opcode/msgcode/subcode to compact indices with hit flags.
module ucie_ctl_sb_rx_code_lookup
    import ucie_ctl_sb_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [MSGC_W-1:0] msgcode_i,
    input  logic [SUBC_W-1:0] subcode_i,
    output logic              op_hit_o,
    output logic              op_idx_o,
    output logic              msg_hit_o,
    output logic [1:0]        msg_idx_o,
    output logic              sub_hit_o,
    output logic [1:0]        sub_idx_o
);

    always_comb begin
        op_hit_o  = 1'b0;
        op_idx_o  = 1'b0;
        msg_hit_o = 1'b0;
        msg_idx_o = '0;
        sub_hit_o = 1'b0;
        sub_idx_o = '0;

        if (opcode_i == OPC_MSG_NODATA) begin
            op_hit_o = 1'b1;
        end else if (opcode_i == OPC_MSG_DATA) begin
            op_hit_o = 1'b1;
            op_idx_o = 1'b1;
        end

        for (int unsigned i = 0; i < N_CODES; i++) begin
            if (msgcode_i == MSGCODE_TBL[i[1:0]]) begin
                msg_hit_o = 1'b1;
                msg_idx_o = i[1:0];
            end
            if (subcode_i == SUBCODE_TBL[i[1:0]]) begin
                sub_hit_o = 1'b1;
                sub_idx_o = i[1:0];
            end
        end
    end

endmodule

// File: rtl/ucie_ctl_sb_rx_decoder.sv
// Sideband RX decoder: accepts header (+ optional payload) words, checks opcode/parity/codes,
// presents a registered decoded message or drops it with a one-cycle error pulse.
module ucie_ctl_sb_rx_decoder
    import ucie_ctl_sb_pkg::*;
#(
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    ucie_ctl_sb_rx_decoder_if.slave  sb
);

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

    sb_rx_state_e             state_q, state_d;
    logic [HDR_W-1:0]         hdr_q, hdr_d;
    logic                     msg_valid_q, msg_valid_d;
    logic                     op_addr_q, op_addr_d;
    logic [1:0]               msg_addr_q, msg_addr_d;
    logic [1:0]               sub_addr_q, sub_addr_d;
    logic [INFO_W-1:0]        info_q, info_d;
    logic [63:0]              data_q, data_d;
    logic                     err_opc_q, err_opc_d;
    logic                     err_par_q, err_par_d;
    logic                     err_code_q, err_code_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic [HDR_W-1:0] lk_hdr;
    logic             accept;
    logic             cp_ok;
    logic             op_hit, op_idx, msg_hit, sub_hit;
    logic [1:0]       msg_idx, sub_idx;
    logic             deliver, drop;

    // One lookup serves both phases: live header in IDLE, the stored header in DATA.
    assign lk_hdr = (state_q == SB_RX_DATA) ? hdr_q : sb.i_sb_data;
    assign accept = sb.i_sb_valid && (state_q != SB_RX_OUT);
    assign cp_ok  = hdr_cp_ok(lk_hdr);

    ucie_ctl_sb_rx_code_lookup u_code_lookup (
        .opcode_i  (lk_hdr[HDR_OPC_LSB  +: OPC_W]),
        .msgcode_i (lk_hdr[HDR_MSGC_LSB +: MSGC_W]),
        .subcode_i (lk_hdr[HDR_SUBC_LSB +: SUBC_W]),
        .op_hit_o  (op_hit),
        .op_idx_o  (op_idx),
        .msg_hit_o (msg_hit),
        .msg_idx_o (msg_idx),
        .sub_hit_o (sub_hit),
        .sub_idx_o (sub_idx)
    );

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        msg_valid_d = msg_valid_q;
        op_addr_d   = op_addr_q;
        msg_addr_d  = msg_addr_q;
        sub_addr_d  = sub_addr_q;
        info_d      = info_q;
        data_d      = data_q;
        err_opc_d   = 1'b0;
        err_par_d   = 1'b0;
        err_code_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
        deliver     = 1'b0;
        drop        = 1'b0;

        unique case (state_q)
            SB_RX_IDLE: begin
                if (accept) begin
                    if (!op_hit) begin
                        drop      = 1'b1;
                        err_opc_d = 1'b1;
                    end else if (op_idx) begin
                        hdr_d   = sb.i_sb_data;
                        state_d = SB_RX_DATA;
                    end else if (!cp_ok || lk_hdr[HDR_DP_BIT]) begin
                        drop      = 1'b1;
                        err_par_d = 1'b1;
                    end else if (!(msg_hit && sub_hit)) begin
                        drop       = 1'b1;
                        err_code_d = 1'b1;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            SB_RX_DATA: begin
                if (accept) begin
                    if (!cp_ok || (lk_hdr[HDR_DP_BIT] != (^sb.i_sb_data))) begin
                        drop      = 1'b1;
                        err_par_d = 1'b1;
                    end else if (!(msg_hit && sub_hit)) begin
                        drop       = 1'b1;
                        err_code_d = 1'b1;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            SB_RX_OUT: begin
                if (sb.i_msg_ready) begin
                    state_d     = SB_RX_IDLE;
                    msg_valid_d = 1'b0;
                end
            end
            default: state_d = SB_RX_IDLE;
        endcase

        if (deliver) begin
            state_d     = SB_RX_OUT;
            msg_valid_d = 1'b1;
            op_addr_d   = op_idx;
            msg_addr_d  = msg_idx;
            sub_addr_d  = sub_idx;
            info_d      = lk_hdr[HDR_INFO_LSB +: INFO_W];
            data_d      = (state_q == SB_RX_DATA) ? sb.i_sb_data : '0;
        end

        if (drop) begin
            state_d = SB_RX_IDLE;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= SB_RX_IDLE;
            hdr_q       <= '0;
            msg_valid_q <= 1'b0;
            op_addr_q   <= 1'b0;
            msg_addr_q  <= '0;
            sub_addr_q  <= '0;
            info_q      <= '0;
            data_q      <= '0;
            err_opc_q   <= 1'b0;
            err_par_q   <= 1'b0;
            err_code_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            msg_valid_q <= msg_valid_d;
            op_addr_q   <= op_addr_d;
            msg_addr_q  <= msg_addr_d;
            sub_addr_q  <= sub_addr_d;
            info_q      <= info_d;
            data_q      <= data_d;
            err_opc_q   <= err_opc_d;
            err_par_q   <= err_par_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign sb.o_sb_ready   = (state_q != SB_RX_OUT);
    assign sb.o_msg_valid  = msg_valid_q;
    assign sb.o_op_addr    = op_addr_q;
    assign sb.o_msg_addr   = msg_addr_q;
    assign sb.o_sub_addr   = sub_addr_q;
    assign sb.o_info_code  = info_q;
    assign sb.o_data       = data_q;
    assign sb.o_err_opcode = err_opc_q;
    assign sb.o_err_parity = err_par_q;
    assign sb.o_err_code   = err_code_q;
    assign sb.o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ucie_ctl_sb_rx_decoder.sv
// Directed self-checking bench for the sideband RX decoder with hand-computed headers.
module tb_ucie_ctl_sb_rx_decoder;

    localparam int unsigned W = 8;

    localparam logic [63:0] H_ND      = 64'h80000000_00004012;
    localparam logic [63:0] H_WD      = 64'hC0000002_0002401B;
    localparam logic [63:0] H_ND_INFO = 64'h00123409_00010012;
    localparam logic [63:0] H_WD2     = 64'h00000000_0000C01B;
    localparam logic [63:0] H_NOCP    = 64'h00000000_00004012;
    localparam logic [63:0] H_BADMSG  = 64'h00000000_00014012;
    localparam logic [63:0] H_BADOPC  = 64'h00000000_00000013;
    localparam logic [63:0] H_PAR_MSG = 64'h80000000_00014012;
    localparam logic [63:0] H_WD_BSUB = 64'h00000005_0000C01B;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ucie_ctl_sb_rx_decoder_if #(.ERR_CNT_WIDTH(W)) sb_if ();

    ucie_ctl_sb_rx_decoder #(.ERR_CNT_WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .sb    (sb_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        sb_if.i_sb_valid = v;
        sb_if.i_sb_data  = d;
    endtask

    task automatic chk_msg(input string tag, input logic op, input logic [1:0] m,
                           input logic [1:0] s, input logic [15:0] info, input logic [63:0] d);
        chk({tag, ".valid"}, 64'(sb_if.o_msg_valid), 64'd1);
        chk({tag, ".ready"}, 64'(sb_if.o_sb_ready), 64'd0);
        chk({tag, ".op"},    64'(sb_if.o_op_addr), 64'(op));
        chk({tag, ".msg"},   64'(sb_if.o_msg_addr), 64'(m));
        chk({tag, ".sub"},   64'(sb_if.o_sub_addr), 64'(s));
        chk({tag, ".info"},  64'(sb_if.o_info_code), 64'(info));
        chk({tag, ".data"},  sb_if.o_data, d);
    endtask

    task automatic chk_err(input string tag, input logic opc, input logic par, input logic code);
        chk({tag, ".err"}, 64'({sb_if.o_err_opcode, sb_if.o_err_parity, sb_if.o_err_code}),
            64'({opc, par, code}));
    endtask

    task automatic chk_drop(input string tag, input logic opc, input logic par, input logic code,
                            input int unsigned cnt);
        chk_err(tag, opc, par, code);
        chk({tag, ".valid"}, 64'(sb_if.o_msg_valid), 64'd0);
        chk({tag, ".cnt"},   64'(sb_if.o_err_cnt), 64'(cnt));
        step();
        chk_err({tag, ".once"}, 1'b0, 1'b0, 1'b0);
        chk({tag, ".nomsg"}, 64'(sb_if.o_msg_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1'b0, '0);
        sb_if.i_msg_ready = 1'b1;
        #1;
        chk("rst.valid", 64'(sb_if.o_msg_valid), 64'd0);
        chk("rst.ready", 64'(sb_if.o_sb_ready), 64'd1);
        chk("rst.cnt",   64'(sb_if.o_err_cnt), 64'd0);
        chk_err("rst", 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // No-data message, then handshake back to IDLE
        drive(1'b1, H_ND); step(); drive(1'b0, '0);
        chk_msg("nd", 1'b0, 2'd0, 2'd0, 16'h0000, 64'h0);
        chk_err("nd", 1'b0, 1'b0, 1'b0);
        step();
        chk("nd.done", 64'(sb_if.o_msg_valid), 64'd0);
        chk("nd.rdy",  64'(sb_if.o_sb_ready), 64'd1);

        // With-data message
        drive(1'b1, H_WD); step();
        chk("wd.hdr", 64'(sb_if.o_msg_valid), 64'd0);
        chk_err("wd.hdr", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h1); step(); drive(1'b0, '0);
        chk_msg("wd", 1'b1, 2'd3, 2'd2, 16'h0000, 64'h1);
        step();

        drive(1'b1, H_ND_INFO); step(); drive(1'b0, '0);
        chk_msg("nd_info", 1'b0, 2'd2, 2'd3, 16'h1234, 64'h0);
        step();

        drive(1'b1, H_WD2); step();
        drive(1'b1, 64'h3); step(); drive(1'b0, '0);
        chk_msg("wd2", 1'b1, 2'd1, 2'd0, 16'h0000, 64'h3);
        step();

        // Error cases and priority
        drive(1'b1, H_NOCP); step(); drive(1'b0, '0);
        chk_drop("par", 1'b0, 1'b1, 1'b0, 1);
        drive(1'b1, H_BADMSG); step(); drive(1'b0, '0);
        chk_drop("code", 1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, H_BADOPC); step(); drive(1'b0, '0);
        chk_drop("opc", 1'b1, 1'b0, 1'b0, 3);
        drive(1'b1, H_PAR_MSG); step(); drive(1'b0, '0);
        chk_drop("par_gt_code", 1'b0, 1'b1, 1'b0, 4);

        drive(1'b1, H_WD); step();
        chk_err("wd_dp.hdr", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h0); step(); drive(1'b0, '0);
        chk_drop("wd_dp", 1'b0, 1'b1, 1'b0, 5);

        drive(1'b1, H_WD_BSUB); step();
        chk_err("wd_sub.hdr", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h3); step(); drive(1'b0, '0);
        chk_drop("wd_sub", 1'b0, 1'b0, 1'b1, 6);

        // Counter saturation: 2^W+3 more dropped messages
        drive(1'b1, 64'h0);
        repeat ((1 << W) + 3) step();
        drive(1'b0, '0);
        chk("sat.cnt", 64'(sb_if.o_err_cnt), 64'((1 << W) - 1));
        chk_err("sat", 1'b1, 1'b0, 1'b0);
        step();
        chk("sat.hold", 64'(sb_if.o_err_cnt), 64'((1 << W) - 1));

        // Backpressure with next header already waiting
        sb_if.i_msg_ready = 1'b0;
        drive(1'b1, H_ND); step();
        drive(1'b1, H_WD);
        for (int i = 0; i < 5; i++) begin
            chk_msg("bp", 1'b0, 2'd0, 2'd0, 16'h0000, 64'h0);
            step();
        end
        sb_if.i_msg_ready = 1'b1;
        chk_msg("bp.hs", 1'b0, 2'd0, 2'd0, 16'h0000, 64'h0);
        step();
        chk("bp.after", 64'(sb_if.o_msg_valid), 64'd0);
        chk("bp.rdy",   64'(sb_if.o_sb_ready), 64'd1);
        step();
        drive(1'b1, 64'h1); step(); drive(1'b0, '0);
        chk_msg("bp.next", 1'b1, 2'd3, 2'd2, 16'h0000, 64'h1);
        chk_err("bp.next", 1'b0, 1'b0, 1'b0);
        step();

        // Reset while in DATA
        drive(1'b1, H_WD); step(); drive(1'b0, '0);
        chk("rd.pre", 64'(sb_if.o_msg_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rd.valid", 64'(sb_if.o_msg_valid), 64'd0);
        chk("rd.data",  sb_if.o_data, 64'h0);
        chk("rd.addr",  64'({sb_if.o_op_addr, sb_if.o_msg_addr, sb_if.o_sub_addr}), 64'd0);
        chk("rd.info",  64'(sb_if.o_info_code), 64'd0);
        chk("rd.cnt",   64'(sb_if.o_err_cnt), 64'd0);
        chk("rd.rdy",   64'(sb_if.o_sb_ready), 64'd1);
        chk_err("rd", 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        chk_err("rd.rel", 1'b0, 1'b0, 1'b0);
        drive(1'b1, H_ND); step(); drive(1'b0, '0);
        chk_msg("rd.idle", 1'b0, 2'd0, 2'd0, 16'h0000, 64'h0);
        chk_err("rd.idle", 1'b0, 1'b0, 1'b0);
        chk("rd.idle.cnt", 64'(sb_if.o_err_cnt), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
